// File: rtl/pool_row_writer_if.sv
// Row-pair writer bus: pixel input stream, bank write port and max-pool handshake.
interface pool_row_writer_if #(
    parameter int BD = 18
);
    logic          in_valid;
    logic          in_ready;
    logic [BD-1:0] in_c0;
    logic [BD-1:0] in_c1;
    logic [BD-1:0] in_c2;
    logic          pool_busy;
    logic          wren0;
    logic          wren1;
    logic [10:0]   wraddr;
    logic [BD-1:0] wd_c0;
    logic [BD-1:0] wd_c1;
    logic [BD-1:0] wd_c2;
    logic          ready_out;
    logic          frame_done;

    modport master (
        input  in_valid, in_c0, in_c1, in_c2, pool_busy,
        output in_ready, wren0, wren1, wraddr,
        output wd_c0, wd_c1, wd_c2, ready_out, frame_done
    );

    modport slave (
        output in_valid, in_c0, in_c1, in_c2, pool_busy,
        input  in_ready, wren0, wren1, wraddr,
        input  wd_c0, wd_c1, wd_c2, ready_out, frame_done
    );
endinterface

// File: rtl/pool_row_writer.sv
// Writes even conv rows to bank 0 and odd rows to bank 1, then hands each pair to max-pool.
// POOL_ROW_WR_ODD_PAD_EN: pad an unpaired last row's bank 1 with most-negative samples.
module pool_row_writer #(
    parameter int BD    = 18,
    parameter int WIDTH = 28,
    parameter int ROWS  = 28
) (
    input  logic              clk,
    input  logic              reset,
    pool_row_writer_if.master bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = $clog2(ROWS + 2);

`ifdef POOL_ROW_WR_ODD_PAD_EN
    typedef enum logic [2:0] {
        FILL_EVEN, FILL_ODD, HANDOFF, DRAIN, PAD
    } state_t;
`else
    typedef enum logic [2:0] {
        FILL_EVEN, FILL_ODD, HANDOFF, DRAIN
    } state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] col, col_n;
    logic [RW-1:0] row, row_n;
    logic [1:0]    gap, gap_n;
    logic          busy_q;
    logic          in_ready_q, in_ready_n;
    logic          ready_q, ready_n;
    logic          fd_q, fd_n;
    logic          we0_q, we0_n;
    logic          we1_q, we1_n;
    logic [10:0]   addr_q, addr_n;
    logic [BD-1:0] d0_q, d0_n;
    logic [BD-1:0] d1_q, d1_n;
    logic [BD-1:0] d2_q, d2_n;
`ifndef POOL_ROW_WR_ODD_PAD_EN
    logic          pend_q, pend_n;
`endif

    logic accept, rise, fall, last_col;

    assign accept   = bus.in_valid & in_ready_q;
    assign rise     = bus.pool_busy & ~busy_q;
    assign fall     = ~bus.pool_busy & busy_q;
    assign last_col = (col == CW'(WIDTH - 1));

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        gap_n   = (gap != 2'd0) ? gap - 2'd1 : 2'd0;
        ready_n = ready_q;
        fd_n    = 1'b0;
        we0_n   = 1'b0;
        we1_n   = 1'b0;
        addr_n  = addr_q;
        d0_n    = d0_q;
        d1_n    = d1_q;
        d2_n    = d2_q;
`ifndef POOL_ROW_WR_ODD_PAD_EN
        pend_n  = 1'b0;
        fd_n    = pend_q;
`endif
        unique case (state)
            FILL_EVEN: begin
                if (accept) begin
                    we0_n  = 1'b1;
                    addr_n = 11'(col);
                    d0_n   = bus.in_c0;
                    d1_n   = bus.in_c1;
                    d2_n   = bus.in_c2;
                    col_n  = last_col ? '0 : col + CW'(1);
                    if (last_col) begin
                        if (row == RW'(ROWS - 1)) begin
`ifdef POOL_ROW_WR_ODD_PAD_EN
                            state_n = PAD;
`else
                            // unpaired last row is never handed off
                            state_n = FILL_EVEN;
                            row_n   = '0;
                            pend_n  = 1'b1;
`endif
                        end else begin
                            state_n = FILL_ODD;
                        end
                    end
                end
            end
            FILL_ODD: begin
                if (accept) begin
                    we1_n  = 1'b1;
                    addr_n = 11'(col);
                    d0_n   = bus.in_c0;
                    d1_n   = bus.in_c1;
                    d2_n   = bus.in_c2;
                    col_n  = last_col ? '0 : col + CW'(1);
                    if (last_col) begin
                        state_n = HANDOFF;
                        row_n   = row + RW'(2);
                    end
                end
            end
            HANDOFF: begin
                // raised one cycle after the final bank-1 write strobe
                ready_n = 1'b1;
                if (rise) state_n = DRAIN;
            end
            DRAIN: begin
                ready_n = 1'b1;
                if (fall) begin
                    ready_n = 1'b0;
                    gap_n   = 2'd2;
                    state_n = FILL_EVEN;
                    if (row >= RW'(ROWS)) begin
                        fd_n  = 1'b1;
                        row_n = '0;
                    end
                end
            end
`ifdef POOL_ROW_WR_ODD_PAD_EN
            PAD: begin
                we1_n  = 1'b1;
                addr_n = 11'(col);
                d0_n   = {1'b1, {(BD - 1){1'b0}}};
                d1_n   = {1'b1, {(BD - 1){1'b0}}};
                d2_n   = {1'b1, {(BD - 1){1'b0}}};
                col_n  = last_col ? '0 : col + CW'(1);
                if (last_col) begin
                    state_n = HANDOFF;
                    row_n   = row + RW'(2);
                end
            end
`endif
            default: state_n = FILL_EVEN;
        endcase
        // gap keeps input held off while ready_out stays low for re-arm
        in_ready_n = ((state_n == FILL_EVEN) || (state_n == FILL_ODD))
                     && (gap_n == 2'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL_EVEN;
            col        <= '0;
            row        <= '0;
            gap        <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            ready_q    <= 1'b0;
            fd_q       <= 1'b0;
            we0_q      <= 1'b0;
            we1_q      <= 1'b0;
            addr_q     <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            gap        <= gap_n;
            busy_q     <= bus.pool_busy;
            in_ready_q <= in_ready_n;
            ready_q    <= ready_n;
            fd_q       <= fd_n;
            we0_q      <= we0_n;
            we1_q      <= we1_n;
            addr_q     <= addr_n;
            d0_q       <= d0_n;
            d1_q       <= d1_n;
            d2_q       <= d2_n;
        end
    end

`ifndef POOL_ROW_WR_ODD_PAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend_q <= 1'b0;
        else        pend_q <= pend_n;
    end
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.wren0      = we0_q;
    assign bus.wren1      = we1_q;
    assign bus.wraddr     = addr_q;
    assign bus.wd_c0      = d0_q;
    assign bus.wd_c1      = d1_q;
    assign bus.wd_c2      = d2_q;
    assign bus.ready_out  = ready_q;
    assign bus.frame_done = fd_q;
endmodule
